// File: rtl/cpu_mem_sequencer_if.sv
// ---------------------------------------------------------------------------
// cpu_mem_sequencer_if
//   Unified memory port between the sequencer (master) and the memory/bus
//   wrapper (slave). A transfer completes on a rising edge where
//   mem_req & mem_ready.
//
//   mem_req    master->slave  request valid
//   mem_we     master->slave  byte write strobes, all-zero = read
//   mem_addr   master->slave  request address
//   mem_wdata  master->slave  write data, lane-aligned
//   mem_rdata  slave->master  read data, valid in the ready cycle
//   mem_ready  slave->master  transfer completes this cycle
// ---------------------------------------------------------------------------
interface cpu_mem_sequencer_if #(
   parameter int AddrWidth   = 32,
   parameter int DataWidth   = 32,
   parameter int StrobeWidth = DataWidth / 8
);
   logic                   mem_req;
   logic [StrobeWidth-1:0] mem_we;
   logic [AddrWidth-1:0]   mem_addr;
   logic [DataWidth-1:0]   mem_wdata;
   logic [DataWidth-1:0]   mem_rdata;
   logic                   mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/cpu_mem_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_mem_sequencer
//   Multi-cycle memory front end for a combinational RV32I datapath. Per
//   instruction: fetch over the unified port, hold the instruction for one
//   evaluate cycle, perform at most one data access, then pulse core_step so
//   the PC and register file update. A run of TimeoutCycles consecutive
//   not-ready cycles parks the sequencer in a sticky fault until reset.
//
//   clk              clock, all state on rising edge
//   rst              synchronous reset, active low
//   core_pc          fetch address from IF
//   core_instr       latched instruction for ID/EXE
//   core_data_req    current instruction needs a data access
//   core_data_we     byte strobes, all-zero = read
//   core_data_addr   data address from MemoryAccess
//   core_data_wdata  store data, lane-aligned
//   core_data_rdata  latched load data
//   core_step        one-cycle commit pulse
//   core_fault       sticky bus-timeout flag
//   mem              unified memory port (master side)
// ---------------------------------------------------------------------------
module cpu_mem_sequencer #(
   parameter int                   AddrWidth     = 32,
   parameter int                   DataWidth     = 32,
   parameter int                   StrobeWidth   = DataWidth / 8,
   parameter int                   TimeoutCycles = 255,
   parameter logic [DataWidth-1:0] NopInstr      = 32'h0000_0013
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [AddrWidth-1:0]   core_pc,
   output logic [DataWidth-1:0]   core_instr,
   input  logic                   core_data_req,
   input  logic [StrobeWidth-1:0] core_data_we,
   input  logic [AddrWidth-1:0]   core_data_addr,
   input  logic [DataWidth-1:0]   core_data_wdata,
   output logic [DataWidth-1:0]   core_data_rdata,
   output logic                   core_step,
   output logic                   core_fault,
   cpu_mem_sequencer_if.master    mem
);

   // A zero timeout disables the fault; keep the counter at least one bit.
   localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_DATA,
      S_COMMIT,
      S_FAULT
   } state_t;

   state_t                 state_q;
   logic                   req_q;
   logic                   step_q;
   logic                   fault_q;
   logic [DataWidth-1:0]   instr_q;
   logic [DataWidth-1:0]   rdata_q;
   logic [AddrWidth-1:0]   daddr_q;
   logic [StrobeWidth-1:0] dwe_q;
   logic [DataWidth-1:0]   dwdata_q;
   logic [CntW-1:0]        wait_q;
   logic [CntW-1:0]        wait_d;
   logic                   timeout_hit;

   assign wait_d = wait_q + 1'b1;

   // True on the last not-ready cycle that is still tolerated; a ready on
   // the same edge takes priority because it is tested first.
   assign timeout_hit = (TimeoutCycles != 0) && (wait_q == CntW'(TimeoutCycles - 1));

   // Bus fields come only from state and latched registers. The fetch address
   // is taken straight from core_pc because the PC register only advances on
   // the commit edge, so it is already the new PC when FETCH starts.
   assign mem.mem_req   = req_q;
   assign mem.mem_addr  = (state_q == S_FETCH) ? core_pc :
                          (state_q == S_DATA)  ? daddr_q : '0;
   assign mem.mem_we    = (state_q == S_DATA) ? dwe_q    : '0;
   assign mem.mem_wdata = (state_q == S_DATA) ? dwdata_q : '0;

   assign core_instr      = instr_q;
   assign core_data_rdata = rdata_q;
   assign core_step       = step_q;
   assign core_fault      = fault_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         req_q    <= 1'b0;
         step_q   <= 1'b0;
         fault_q  <= 1'b0;
         instr_q  <= NopInstr;
         rdata_q  <= '0;
         daddr_q  <= '0;
         dwe_q    <= '0;
         dwdata_q <= '0;
         wait_q   <= '0;
      end else begin
         step_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               state_q <= S_FETCH;
               req_q   <= 1'b1;
               wait_q  <= '0;
            end
            S_FETCH: begin
               if (mem.mem_ready) begin
                  instr_q <= mem.mem_rdata;
                  req_q   <= 1'b0;
                  wait_q  <= '0;
                  state_q <= S_EXEC;
               end else if (timeout_hit) begin
                  req_q   <= 1'b0;
                  fault_q <= 1'b1;
                  state_q <= S_FAULT;
               end else begin
                  wait_q <= wait_d;
               end
            end
            S_EXEC: begin
               // Snapshot the request so the core may change its data-side
               // outputs freely while the access is outstanding.
               daddr_q  <= core_data_addr;
               dwe_q    <= core_data_we;
               dwdata_q <= core_data_wdata;
               if (core_data_req) begin
                  req_q   <= 1'b1;
                  wait_q  <= '0;
                  state_q <= S_DATA;
               end else begin
                  step_q  <= 1'b1;
                  state_q <= S_COMMIT;
               end
            end
            S_DATA: begin
               if (mem.mem_ready) begin
                  if (dwe_q == '0) begin
                     rdata_q <= mem.mem_rdata;
                  end
                  req_q   <= 1'b0;
                  wait_q  <= '0;
                  step_q  <= 1'b1;
                  state_q <= S_COMMIT;
               end else if (timeout_hit) begin
                  req_q   <= 1'b0;
                  fault_q <= 1'b1;
                  state_q <= S_FAULT;
               end else begin
                  wait_q <= wait_d;
               end
            end
            S_COMMIT: begin
               req_q   <= 1'b1;
               wait_q  <= '0;
               state_q <= S_FETCH;
            end
            S_FAULT: begin
               req_q   <= 1'b0;
               fault_q <= 1'b1;
            end
            default: begin
               req_q   <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_mem_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_mem_sequencer
//   The bench plays both the core and the memory. Each planned instruction
//   pushes its expected bus requests and its expected commit (instruction,
//   load data, cycles since previous commit) into queues; a negedge monitor
//   pops and compares whenever the DUT issues a request or pulses core_step.
// ---------------------------------------------------------------------------
module tb_cpu_mem_sequencer;

   localparam int NEVER = 1000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] core_pc;
   logic [31:0] core_instr;
   logic        core_data_req;
   logic [3:0]  core_data_we;
   logic [31:0] core_data_addr;
   logic [31:0] core_data_wdata;
   logic [31:0] core_data_rdata;
   logic        core_step;
   logic        core_fault;

   always #5 clk = ~clk;

   cpu_mem_sequencer_if #(.AddrWidth(32), .DataWidth(32)) mem_if ();

   cpu_mem_sequencer #(
      .AddrWidth(32), .DataWidth(32), .StrobeWidth(4),
      .TimeoutCycles(4), .NopInstr(32'h0000_0013)
   ) dut (
      .clk(clk),
      .rst(rst),
      .core_pc(core_pc),
      .core_instr(core_instr),
      .core_data_req(core_data_req),
      .core_data_we(core_data_we),
      .core_data_addr(core_data_addr),
      .core_data_wdata(core_data_wdata),
      .core_data_rdata(core_data_rdata),
      .core_step(core_step),
      .core_fault(core_fault),
      .mem(mem_if)
   );

   typedef struct {
      logic [31:0] pc;
      bit          req;
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          wf;
      int          wd;
   } instr_t;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] wdata;
      bit          chk_wdata;
   } bus_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] rdata;
      int          delta;
   } commit_t;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem_m [0:127];
   instr_t  dir_q[$];
   bus_t    exp_bus[$];
   commit_t exp_commit[$];
   int          waits_q[$];
   logic [31:0] data_q[$];
   bit          kind_q[$];

   // environment state
   bit          need_plan;
   bit          prev_step;
   bit          busy;
   int          cur_wait;
   logic [31:0] cur_data;
   bit          cur_kind;
   bit          cur_never;
   int          scr;
   int          rand_left;
   int          nr_count;
   logic [31:0] rdata_model;

   // monitor state
   int    cyc;
   int    last_step;
   bit    in_req;
   bus_t  cur_bus;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(logic [31:0] a);
      return mem_m[a[8:2]];
   endfunction

   function automatic instr_t mk(logic [31:0] pc, bit req, logic [3:0] we,
                                 logic [31:0] addr, logic [31:0] wdata, int wf, int wd);
      instr_t t;
      t.pc = pc; t.req = req; t.we = we; t.addr = addr;
      t.wdata = wdata; t.wf = wf; t.wd = wd;
      return t;
   endfunction

   task automatic plan(instr_t t);
      bus_t        b;
      commit_t     c;
      logic [31:0] w;
      core_pc         = t.pc;
      core_data_req   = t.req;
      core_data_we    = t.we;
      core_data_addr  = t.addr;
      core_data_wdata = t.wdata;
      waits_q.push_back(t.wf);
      data_q.push_back(mem_rd(t.pc));
      kind_q.push_back(1'b0);
      b.addr = t.pc; b.we = 4'b0; b.wdata = 32'h0; b.chk_wdata = 1'b0;
      exp_bus.push_back(b);
      if (t.wf == NEVER) return;
      c.delta = 3 + t.wf;
      if (t.req) begin
         c.delta += 1 + t.wd;
         waits_q.push_back(t.wd);
         kind_q.push_back(1'b1);
         b.addr = t.addr; b.we = t.we; b.wdata = t.wdata; b.chk_wdata = 1'b1;
         exp_bus.push_back(b);
         if (t.we == 4'b0) begin
            rdata_model = mem_rd(t.addr);
            data_q.push_back(rdata_model);
         end else begin
            data_q.push_back($urandom);
            w = mem_rd(t.addr);
            for (int k = 0; k < 4; k++)
               if (t.we[k]) w[8*k +: 8] = t.wdata[8*k +: 8];
            mem_m[t.addr[8:2]] = w;
         end
      end
      c.instr = mem_rd(t.pc);
      c.rdata = rdata_model;
      exp_commit.push_back(c);
   endtask

   task automatic plan_next();
      instr_t t;
      if (dir_q.size() > 0) begin
         t = dir_q.pop_front();
      end else if (rand_left > 0) begin
         rand_left--;
         t = mk({22'h0, 6'($urandom_range(0, 63)), 2'b00}, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0,
                32'h100 + 32'(4 * $urandom_range(0, 15)), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
         t = mk({22'h0, 6'($urandom_range(0, 63)), 2'b00}, 1'b0, 4'b0, 32'h0, 32'h0, NEVER, 0);
      end
      plan(t);
   endtask

   task automatic env_reset();
      waits_q.delete(); data_q.delete(); kind_q.delete();
      exp_bus.delete(); exp_commit.delete();
      need_plan = 1'b1; prev_step = 1'b0; busy = 1'b0; scr = 0;
      nr_count = 0; rdata_model = 32'h0;
      mem_if.mem_ready = 1'b0;
   endtask

   // One environment step, called #1 after each rising edge.
   task automatic env_cycle();
      if (need_plan || prev_step) begin
         plan_next();
         need_plan = 1'b0;
      end
      prev_step = core_step;
      // Garble the core's data-side outputs after EXEC; the DUT must use its copy.
      if (scr > 0) begin
         scr--;
         if (scr == 0) begin
            core_data_req   = 1'($urandom_range(0, 1));
            core_data_we    = 4'($urandom_range(0, 15));
            core_data_addr  = $urandom;
            core_data_wdata = $urandom;
         end
      end
      if (mem_if.mem_req) begin
         if (!busy) begin
            busy = 1'b1;
            if (waits_q.size() > 0) begin
               cur_wait = waits_q.pop_front();
               cur_data = data_q.pop_front();
               cur_kind = kind_q.pop_front();
            end else begin
               cur_wait = NEVER; cur_data = 32'h0; cur_kind = 1'b0;
            end
            cur_never = (cur_wait == NEVER);
         end
         if (cur_wait == 0) begin
            mem_if.mem_ready = 1'b1;
            mem_if.mem_rdata = cur_data;
            busy = 1'b0;
            if (!cur_kind) scr = 2;
         end else begin
            mem_if.mem_ready = 1'b0;
            mem_if.mem_rdata = $urandom;
            cur_wait--;
            if (cur_never) nr_count++;
         end
      end else begin
         mem_if.mem_ready = 1'($urandom_range(0, 1));
         mem_if.mem_rdata = $urandom;
      end
   endtask

   task automatic reset_checks();
      chk("rst_mem_req",   32'(mem_if.mem_req), 32'h0);
      chk("rst_mem_we",    32'(mem_if.mem_we), 32'h0);
      chk("rst_mem_addr",  mem_if.mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_if.mem_wdata, 32'h0);
      chk("rst_instr",     core_instr, 32'h0000_0013);
      chk("rst_rdata",     core_data_rdata, 32'h0);
      chk("rst_step",      32'(core_step), 32'h0);
      chk("rst_fault",     32'(core_fault), 32'h0);
   endtask

   // Run from reset release until the final never-ready fetch faults.
   task automatic run_until_fault();
      bit seen = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         if (i == 0) chk("first_req", 32'(mem_if.mem_req), 32'h1);
         if (core_fault) begin
            seen = 1'b1;
            break;
         end
         env_cycle();
      end
      if (!seen) begin
         bad++; total++;
         $display("FAIL fault_budget actual=no_fault required=fault");
      end
      chk("fault_wait_cycles", 32'(nr_count), 32'd4);
      chk("fault_req_low",     32'(mem_if.mem_req), 32'h0);
      chk("commits_drained",   32'(exp_commit.size()), 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         env_cycle();
         chk("fault_sticky", 32'(core_fault), 32'h1);
         chk("fault_no_req", 32'(mem_if.mem_req), 32'h0);
      end
   endtask

   // Scoreboard monitor.
   initial begin
      commit_t c;
      cyc = 0; last_step = 0; in_req = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            cyc = 0; last_step = 0; in_req = 1'b0;
         end else begin
            if (mem_if.mem_req) begin
               if (!in_req) begin
                  if (exp_bus.size() == 0) begin
                     bad++; total++;
                     $display("FAIL unexpected_req actual=addr_%h required=no_request", mem_if.mem_addr);
                     cur_bus.addr = mem_if.mem_addr; cur_bus.we = mem_if.mem_we;
                     cur_bus.wdata = mem_if.mem_wdata; cur_bus.chk_wdata = 1'b0;
                  end else begin
                     cur_bus = exp_bus.pop_front();
                  end
                  in_req = 1'b1;
               end
               chk("bus_addr", mem_if.mem_addr, cur_bus.addr);
               chk("bus_we", 32'(mem_if.mem_we), 32'(cur_bus.we));
               if (cur_bus.chk_wdata) chk("bus_wdata", mem_if.mem_wdata, cur_bus.wdata);
               if (mem_if.mem_ready) in_req = 1'b0;
            end else begin
               in_req = 1'b0;
            end
            if (core_step) begin
               if (exp_commit.size() == 0) begin
                  bad++; total++;
                  $display("FAIL unexpected_step actual=step_at_%0d required=no_step", cyc);
               end else begin
                  c = exp_commit.pop_front();
                  chk("step_instr", core_instr, c.instr);
                  chk("step_rdata", core_data_rdata, c.rdata);
                  chk("step_delta", 32'(cyc - last_step), 32'(c.delta));
                  $display("commit instr=%h rdata=%h cycles=%0d", core_instr, core_data_rdata, cyc - last_step);
               end
               last_step = cyc;
            end
            cyc++;
         end
      end
   end

   // Stimulus.
   initial begin
      for (int k = 0; k < 128; k++) mem_m[k] = (32'(k) * 32'h9E37_79B1) ^ 32'h5A00_0013;
      mem_m[0] = 32'h0000_0013;            // addi x0,x0,0
      mem_m[1] = 32'h1000_2083;            // lw
      rst = 1'b0;
      core_pc = 32'h0; core_data_req = 1'b0; core_data_we = 4'b0;
      core_data_addr = 32'h0; core_data_wdata = 32'h0;
      mem_if.mem_rdata = 32'h0;
      env_reset();
      repeat (3) @(posedge clk);
      #1;
      reset_checks();

      // Phase 1: zero-wait addi then lw, waited fetch, waited store,
      // ready on the last tolerated cycle, random traffic, then timeout.
      dir_q.push_back(mk(32'h0,  1'b0, 4'b0,    32'h0,   32'h0,         0, 0));
      dir_q.push_back(mk(32'h4,  1'b1, 4'b0,    32'h100, 32'hDEAD_BEEF, 0, 0));
      dir_q.push_back(mk(32'h8,  1'b0, 4'b0,    32'h0,   32'h0,         2, 0));
      dir_q.push_back(mk(32'hC,  1'b1, 4'b0011, 32'h100, 32'h1234_ABCD, 0, 3));
      dir_q.push_back(mk(32'h10, 1'b1, 4'b0,    32'h100, 32'h0,         3, 3));
      rand_left = 40;
      rst = 1'b1;
      run_until_fault();

      // Phase 2: reset during a data wait, then restart from core_pc.
      rst = 1'b0;
      env_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_checks();
      dir_q.push_back(mk(32'h40, 1'b1, 4'b0, 32'h120, 32'h0, 0, 3));
      dir_q.push_back(mk(32'h40, 1'b0, 4'b0, 32'h0,   32'h0, 0, 0));
      rand_left = 10;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         env_cycle();
      end
      @(posedge clk); #1;
      chk("mid_data_req",  32'(mem_if.mem_req), 32'h1);
      chk("mid_data_addr", mem_if.mem_addr, 32'h120);
      rst = 1'b0;
      env_reset();
      @(posedge clk); #1;
      chk("abort_req",   32'(mem_if.mem_req), 32'h0);
      chk("abort_instr", core_instr, 32'h0000_0013);
      chk("abort_step",  32'(core_step), 32'h0);
      chk("abort_rdata", core_data_rdata, 32'h0);
      rst = 1'b1;
      run_until_fault();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
